// File: rtl/div_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_pipe_ctrl
//  Purpose  : Transaction sequencer for the y = sign | a*b*cos(c)/(a+d) path:
//             d-accumulation init, operand capture, divider start, FIFO
//             push/pop pairing, held result handshake and divider watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module div_pipe_ctrl #(
    parameter int INIT_CYCLES = 12,
    parameter int FILL_LAT    = 2,
    parameter int OUT_LAT     = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cap_en,
    output logic       init_en,
    output logic [3:0] init_cnt,
    output logic       init_done,
    output logic       div_start,
    input  logic       div_done,
    output logic       fifo_wr,
    output logic       fifo_rd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_timeout,
    output logic       err_proto
);

    localparam int CNT_W = $clog2(TIMEOUT + FILL_LAT + OUT_LAT + 1);

    localparam logic [2:0] c_INIT  = 3'd0;
    localparam logic [2:0] c_IDLE  = 3'd1;
    localparam logic [2:0] c_FILL  = 3'd2;
    localparam logic [2:0] c_DIV   = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_HOLD  = 3'd5;

    localparam logic [3:0]       c_INIT_LAST  = 4'(INIT_CYCLES - 1);
    localparam logic [3:0]       c_INIT_END   = 4'(INIT_CYCLES);
    localparam logic [3:0]       c_INIT_ONE   = 4'd1;
    localparam logic [CNT_W-1:0] c_FILL_LAST  = CNT_W'(FILL_LAT - 1);
    localparam logic [CNT_W-1:0] c_WD_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'(OUT_LAT - 2);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    // With a single-cycle output latency the DRAIN state is skipped entirely.
    localparam logic [2:0]       c_POST_DIV   = (OUT_LAT == 1) ? c_HOLD : c_DRAIN;

    logic [2:0]       r_state;
    logic [3:0]       r_init_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_timeout;
    logic             r_err_proto;

    logic w_run;
    logic w_in_div;
    logic w_timeout;
    logic w_proto;

    // Every output is forced low while rst is asserted, whatever the state.
    assign w_run     = ~rst;
    assign w_in_div  = (r_state == c_DIV);
    assign w_timeout = w_run & w_in_div & ~div_done & (r_cnt == c_WD_LAST);
    assign w_proto   = w_run & ~w_in_div & div_done;

    assign init_en     = w_run & (r_state == c_INIT);
    assign init_cnt    = w_run ? r_init_cnt : 4'd0;
    assign init_done   = w_run & (r_state != c_INIT);
    assign in_ready    = w_run & (r_state == c_IDLE);
    assign cap_en      = in_ready & in_valid;
    assign div_start   = w_run & (r_state == c_FILL) & (r_cnt == c_FILL_LAST);
    assign fifo_wr     = div_start;
    assign fifo_rd     = (w_run & w_in_div & div_done) | w_timeout;
    assign out_valid   = w_run & (r_state == c_HOLD);
    assign err_timeout = w_run & (r_err_timeout | w_timeout);
    assign err_proto   = w_run & (r_err_proto | w_proto);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_INIT;
            r_init_cnt    <= 4'd0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
            r_err_proto   <= 1'b0;
        end else begin
            if (w_timeout) r_err_timeout <= 1'b1;
            if (w_proto)   r_err_proto   <= 1'b1;
            case (r_state)
                c_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_state    <= c_IDLE;
                        r_init_cnt <= c_INIT_END;
                    end else begin
                        r_init_cnt <= r_init_cnt + c_INIT_ONE;
                    end
                end
                c_IDLE: begin
                    if (in_valid) begin
                        r_state <= c_FILL;
                        r_cnt   <= '0;
                    end
                end
                c_FILL: begin
                    if (r_cnt == c_FILL_LAST) begin
                        r_state <= c_DIV;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DIV: begin
                    // A completion on the final watchdog cycle still counts as success.
                    if (div_done) begin
                        r_state <= c_POST_DIV;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_WD_LAST) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DRAIN: begin
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_state <= c_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_HOLD: begin
                    if (out_ready) r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
